gpu_frontend_multi: RTL and testbench

//  Parametrised SPI command frontend for the GPU: receives fixed-length LSB-first SPI frames and

---
 rtl/gpu_frontend_multi.sv | 255 +++++++++++++++++++++++++
 tb/tb_gpu_frontend_multi.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gpu_frontend_multi.sv
// SPI command frontend: captures LSB-first frames and holds background, screen enable and polygon slots.
// Optional FRONTEND_READBACK_EN adds slot readback on miso_out (cmd 0xC0|s).
module gpu_frontend_multi #(
    parameter int unsigned N_POLY  = 4,
    parameter int unsigned X_W     = 7,
    parameter int unsigned Y_W     = 6,
    parameter int unsigned COLOR_W = 6,
    parameter int unsigned DEPTH_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cs_in,
    input  logic                         mosi_in,
    input  logic                         sck_in,
    input  logic                         en_load,
    output logic                         miso_out,
    output logic [COLOR_W-1:0]           bg_color_out,
    output logic                         screen_en_out,
    output logic [N_POLY*COLOR_W-1:0]    poly_color_out,
    output logic [N_POLY*X_W-1:0]        v0_x_out,
    output logic [N_POLY*X_W-1:0]        v1_x_out,
    output logic [N_POLY*X_W-1:0]        v2_x_out,
    output logic [N_POLY*Y_W-1:0]        v0_y_out,
    output logic [N_POLY*Y_W-1:0]        v1_y_out,
    output logic [N_POLY*Y_W-1:0]        v2_y_out,
    output logic [N_POLY*DEPTH_W-1:0]    poly_depth_out,
    output logic [N_POLY-1:0]            poly_enable_out,
    output logic                         cmd_done_out,
    output logic                         cmd_err_out
);

    localparam int unsigned PAY_W   = COLOR_W + 3*X_W + 3*Y_W + DEPTH_W;
    localparam int unsigned FRAME_W = 8 + PAY_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned OFF_V0X = COLOR_W;
    localparam int unsigned OFF_V1X = OFF_V0X + X_W;
    localparam int unsigned OFF_V2X = OFF_V1X + X_W;
    localparam int unsigned OFF_V0Y = OFF_V2X + X_W;
    localparam int unsigned OFF_V1Y = OFF_V0Y + Y_W;
    localparam int unsigned OFF_V2Y = OFF_V1Y + Y_W;
    localparam int unsigned OFF_D   = OFF_V2Y + Y_W;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           sck_sync_q;
    logic [1:0]           cs_sync_q, mosi_sync_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [FRAME_W-1:0]   frame_q;

    logic [N_POLY-1:0][COLOR_W-1:0] poly_color_q;
    logic [N_POLY-1:0][X_W-1:0]     v0_x_q, v1_x_q, v2_x_q;
    logic [N_POLY-1:0][Y_W-1:0]     v0_y_q, v1_y_q, v2_y_q;
    logic [N_POLY-1:0][DEPTH_W-1:0] depth_q;
    logic [N_POLY-1:0]              enable_q;
    logic [COLOR_W-1:0]             bg_q;
    logic                           screen_q, done_q, err_q;

    logic                cs_s, mosi_s, rise_en;
    logic [7:0]          cmd_c;
    logic [4:0]          slot_c;
    logic [PAY_W-1:0]    pay_c;
    logic                slot_ok_c;
    logic                wr_c, clr_c, on_c, off_c, bg_c, rd_c, ok_c, err_c;

    // Input synchronisers; cs idles high so it resets to 1
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], sck_in};
            cs_sync_q   <= {cs_sync_q[0], cs_in};
            mosi_sync_q <= {mosi_sync_q[0], mosi_in};
        end
    end

    assign cs_s    = cs_sync_q[1];
    assign mosi_s  = mosi_sync_q[1];
    assign rise_en = (sck_sync_q[2:1] == 2'b01) & en_load;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cs_s) state_d = SHIFT;
            SHIFT: begin
                if (cs_s)
                    state_d = IDLE;
                else if (rise_en && bit_cnt_q == CNT_W'(FRAME_W - 1))
                    state_d = COMMIT;
            end
            COMMIT:  state_d = DONE;
            DONE:    if (cs_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame shifts in from the top so the first bit received ends at bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            frame_q   <= '0;
        end else if (cs_s && state_q != COMMIT) begin
            bit_cnt_q <= '0;
            frame_q   <= '0;
        end else if (state_q == SHIFT && rise_en) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            frame_q   <= {mosi_s, frame_q[FRAME_W-1:1]};
        end
    end

    assign cmd_c     = frame_q[7:0];
    assign slot_c    = cmd_c[4:0];
    assign pay_c     = frame_q[FRAME_W-1:8];
    assign slot_ok_c = {27'd0, slot_c} < N_POLY;

    // Command decode, active only in the COMMIT cycle
    always_comb begin
        wr_c  = 1'b0;
        clr_c = 1'b0;
        on_c  = 1'b0;
        off_c = 1'b0;
        bg_c  = 1'b0;
        rd_c  = 1'b0;
        ok_c  = 1'b0;
        err_c = 1'b0;
        if (state_q == COMMIT) begin
            wr_c  = (cmd_c[7:5] == 3'b100) && slot_ok_c;
            clr_c = (cmd_c[7:5] == 3'b010) && slot_ok_c;
            on_c  = (cmd_c == 8'h21);
            off_c = (cmd_c == 8'h20);
            bg_c  = (cmd_c == 8'h01);
`ifdef FRONTEND_READBACK_EN
            rd_c  = (cmd_c[7:5] == 3'b110) && slot_ok_c;
`endif
            ok_c  = wr_c | clr_c | on_c | off_c | bg_c | rd_c;
            err_c = ~ok_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            poly_color_q <= '0;
            v0_x_q       <= '0;
            v1_x_q       <= '0;
            v2_x_q       <= '0;
            v0_y_q       <= '0;
            v1_y_q       <= '0;
            v2_y_q       <= '0;
            depth_q      <= '0;
            enable_q     <= '0;
            bg_q         <= '0;
            screen_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= ok_c;
            err_q  <= err_c;
            if (on_c)  screen_q <= 1'b1;
            if (off_c) screen_q <= 1'b0;
            if (bg_c)  bg_q     <= pay_c[COLOR_W-1:0];
            for (int k = 0; k < int'(N_POLY); k++) begin
                if (slot_c == 5'(k)) begin
                    if (wr_c) begin
                        poly_color_q[k] <= pay_c[COLOR_W-1:0];
                        v0_x_q[k]       <= pay_c[OFF_V0X +: X_W];
                        v1_x_q[k]       <= pay_c[OFF_V1X +: X_W];
                        v2_x_q[k]       <= pay_c[OFF_V2X +: X_W];
                        v0_y_q[k]       <= pay_c[OFF_V0Y +: Y_W];
                        v1_y_q[k]       <= pay_c[OFF_V1Y +: Y_W];
                        v2_y_q[k]       <= pay_c[OFF_V2Y +: Y_W];
                        depth_q[k]      <= pay_c[OFF_D +: DEPTH_W];
                        enable_q[k]     <= 1'b1;
                    end else if (clr_c) begin
                        poly_color_q[k] <= '0;
                        v0_x_q[k]       <= '0;
                        v1_x_q[k]       <= '0;
                        v2_x_q[k]       <= '0;
                        v0_y_q[k]       <= '0;
                        v1_y_q[k]       <= '0;
                        v2_y_q[k]       <= '0;
                        depth_q[k]      <= '0;
                        enable_q[k]     <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef FRONTEND_READBACK_EN
    logic [PAY_W-1:0] rd_sh_q, rd_pay_c;
    logic             rd_act_q, rd_skip_q, rd_hit_c, fall;
    logic [7:0]       cmd8_c;

    assign fall   = (sck_sync_q[2:1] == 2'b10);
    assign cmd8_c = {mosi_s, frame_q[FRAME_W-1 -: 7]};
    assign rd_hit_c = (state_q == SHIFT) && !cs_s && rise_en &&
                      (bit_cnt_q == CNT_W'(7)) && (cmd8_c[7:5] == 3'b110) &&
                      ({27'd0, cmd8_c[4:0]} < N_POLY);

    always_comb begin
        rd_pay_c = '0;
        for (int k = 0; k < int'(N_POLY); k++) begin
            if (cmd8_c[4:0] == 5'(k))
                rd_pay_c = {depth_q[k], v2_y_q[k], v1_y_q[k], v0_y_q[k],
                            v2_x_q[k], v1_x_q[k], v0_x_q[k], poly_color_q[k]};
        end
    end

    // The fall right after the loading rise is skipped so payload bit 0 is sampled on the next rise
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sh_q   <= '0;
            rd_act_q  <= 1'b0;
            rd_skip_q <= 1'b0;
        end else if (state_q == IDLE || (cs_s && state_q != COMMIT)) begin
            rd_sh_q   <= '0;
            rd_act_q  <= 1'b0;
            rd_skip_q <= 1'b0;
        end else if (rd_hit_c) begin
            rd_sh_q   <= rd_pay_c;
            rd_act_q  <= 1'b1;
            rd_skip_q <= 1'b1;
        end else if (rd_act_q && fall) begin
            if (rd_skip_q) rd_skip_q <= 1'b0;
            else           rd_sh_q   <= {1'b0, rd_sh_q[PAY_W-1:1]};
        end
    end

    assign miso_out = rd_act_q & rd_sh_q[0];
`else
    assign miso_out = 1'b0;
`endif

    assign bg_color_out    = bg_q;
    assign screen_en_out   = screen_q;
    assign poly_color_out  = poly_color_q;
    assign v0_x_out        = v0_x_q;
    assign v1_x_out        = v1_x_q;
    assign v2_x_out        = v2_x_q;
    assign v0_y_out        = v0_y_q;
    assign v1_y_out        = v1_y_q;
    assign v2_y_out        = v2_y_q;
    assign poly_depth_out  = depth_q;
    assign poly_enable_out = enable_q;
    assign cmd_done_out    = done_q;
    assign cmd_err_out     = err_q;

endmodule

// File: tb/tb_gpu_frontend_multi.sv
// Directed bench for gpu_frontend_multi with default parameters (N_POLY=4, 56-bit frames).
module tb_gpu_frontend_multi;

    logic        clk = 1'b0;
    logic        rst, cs, mosi, sck, en_load;
    logic        miso;
    logic [5:0]  bg_color;
    logic        screen_en;
    logic [23:0] poly_color;
    logic [27:0] v0_x, v1_x, v2_x;
    logic [23:0] v0_y, v1_y, v2_y;
    logic [11:0] poly_depth;
    logic [3:0]  poly_enable;
    logic        cmd_done, cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int d0, e0;
    logic [55:0] rx;

    localparam logic [47:0] P2 = {3'd6, 6'd0, 6'd60, 6'd3, 7'd127, 7'd100, 7'd5, 6'h2A};
    localparam logic [47:0] P1 = {3'd5, 6'd33, 6'd17, 6'd1, 7'd64, 7'd9, 7'd2, 6'h3C};

    always #5 clk = ~clk;

    gpu_frontend_multi dut (
        .clk(clk), .rst(rst), .cs_in(cs), .mosi_in(mosi), .sck_in(sck), .en_load(en_load),
        .miso_out(miso), .bg_color_out(bg_color), .screen_en_out(screen_en),
        .poly_color_out(poly_color), .v0_x_out(v0_x), .v1_x_out(v1_x), .v2_x_out(v2_x),
        .v0_y_out(v0_y), .v1_y_out(v1_y), .v2_y_out(v2_y), .poly_depth_out(poly_depth),
        .poly_enable_out(poly_enable), .cmd_done_out(cmd_done), .cmd_err_out(cmd_err)
    );

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (cmd_done) done_cnt++;
        if (cmd_err)  err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends nbits of {pay, cmd} LSB first; samples miso just before each rise
    task automatic send_frame(input logic [7:0] cmd, input logic [47:0] pay, input int nbits,
                              output logic [55:0] rx_o);
        logic [55:0] f;
        f    = {pay, cmd};
        rx_o = '0;
        d0   = done_cnt;
        e0   = err_cnt;
        cs   = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            mosi = f[i];
            tick(5);
            rx_o[i] = miso;
            sck = 1'b1;
            tick(5);
            sck = 1'b0;
        end
        tick(6);
        cs = 1'b1;
        tick(10);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; mosi = 1'b0; sck = 1'b0; en_load = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(3);
        check_eq("reset_enable", 64'(poly_enable), 64'h0);
        check_eq("reset_color", 64'(poly_color), 64'h0);
        check_eq("reset_screen", 64'(screen_en), 64'h0);
        check_eq("reset_miso", 64'(miso), 64'h0);

        send_frame(8'h82, P2, 56, rx);
        check_eq("wr2_color", 64'(poly_color), 64'h02A000);
        check_eq("wr2_v0x", 64'(v0_x), 64'h0014000);
        check_eq("wr2_v1x", 64'(v1_x), 64'h0190000);
        check_eq("wr2_v2x", 64'(v2_x), 64'h01FC000);
        check_eq("wr2_v0y", 64'(v0_y), 64'h003000);
        check_eq("wr2_v1y", 64'(v1_y), 64'h03C000);
        check_eq("wr2_v2y", 64'(v2_y), 64'h0);
        check_eq("wr2_depth", 64'(poly_depth), 64'h180);
        check_eq("wr2_enable", 64'(poly_enable), 64'h4);
        check_eq("wr2_done", 64'(done_cnt - d0), 64'd1);
        check_eq("wr2_err", 64'(err_cnt - e0), 64'd0);

        send_frame(8'h42, 48'h0, 56, rx);
        check_eq("clr2_color", 64'(poly_color), 64'h0);
        check_eq("clr2_v1x", 64'(v1_x), 64'h0);
        check_eq("clr2_enable", 64'(poly_enable), 64'h0);
        check_eq("clr2_done", 64'(done_cnt - d0), 64'd1);

        send_frame(8'h81, P1, 30, rx);
        check_eq("abort_enable", 64'(poly_enable), 64'h0);
        check_eq("abort_color", 64'(poly_color), 64'h0);
        check_eq("abort_pulses", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);

        send_frame(8'h81, P1, 56, rx);
        check_eq("wr1_enable", 64'(poly_enable), 64'h2);
        check_eq("wr1_color", 64'(poly_color), 64'h000F00);
        check_eq("wr1_depth", 64'(poly_depth), 64'h028);
        check_eq("wr1_done", 64'(done_cnt - d0), 64'd1);

        send_frame(8'h85, P2, 56, rx);
        check_eq("badslot_err", 64'(err_cnt - e0), 64'd1);
        check_eq("badslot_done", 64'(done_cnt - d0), 64'd0);
        check_eq("badslot_enable", 64'(poly_enable), 64'h2);
        check_eq("badslot_color", 64'(poly_color), 64'h000F00);

        en_load = 1'b0;
        send_frame(8'h21, 48'h0, 56, rx);
        en_load = 1'b1;
        check_eq("noload_screen", 64'(screen_en), 64'h0);
        check_eq("noload_pulses", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);

        send_frame(8'h21, 48'h0, 56, rx);
        check_eq("screen_on", 64'(screen_en), 64'h1);
        send_frame(8'h01, 48'h15, 56, rx);
        check_eq("bg_color", 64'(bg_color), 64'h15);
        check_eq("bg_done", 64'(done_cnt - d0), 64'd1);

        send_frame(8'hC1, 48'h0, 56, rx);
`ifdef FRONTEND_READBACK_EN
        check_eq("rd1_done", 64'(done_cnt - d0), 64'd1);
        check_eq("rd1_payload", 64'(rx[55:8]), 64'(P1));
        check_eq("rd1_enable", 64'(poly_enable), 64'h2);
`else
        check_eq("rd_unknown_err", 64'(err_cnt - e0), 64'd1);
        check_eq("rd_unknown_done", 64'(done_cnt - d0), 64'd0);
        check_eq("rd_unknown_miso", 64'(rx), 64'h0);
`endif
        check_eq("idle_miso", 64'(miso), 64'h0);

        // Reset in the middle of a frame
        cs = 1'b0;
        tick(6);
        for (int i = 0; i < 20; i++) begin
            mosi = i[0];
            tick(5);
            sck = 1'b1;
            tick(5);
            sck = 1'b0;
        end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        cs = 1'b1;
        tick(10);
        check_eq("rstmid_enable", 64'(poly_enable), 64'h0);
        check_eq("rstmid_color", 64'(poly_color), 64'h0);
        check_eq("rstmid_bg", 64'(bg_color), 64'h0);
        check_eq("rstmid_screen", 64'(screen_en), 64'h0);

        send_frame(8'h83, P2, 56, rx);
        check_eq("wr3_enable", 64'(poly_enable), 64'h8);
        check_eq("wr3_color", 64'(poly_color), 64'hA80000);
        check_eq("wr3_done", 64'(done_cnt - d0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
